// File: rtl/filter_scheduler_pkg.sv
// Shared definitions for the period-measurement filter scheduler: FSM encoding,
// default sizing constants and an index-width helper.
package filter_scheduler_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_COLLECT,
        ST_WAIT_RES,
        ST_PUBLISH
    } state_e;

    localparam int DEF_N_CH      = 4;
    localparam int DEF_M_SAMPLES = 16;
    localparam int DEF_TIMEOUT   = 1024;

    // A single channel still needs a one-bit index.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/filter_scheduler_rr_arbiter.sv
// Round-robin grant selection: picks the first requesting channel strictly after
// last_grant, wrapping modulo N_CH.
module rr_arbiter
    import filter_scheduler_pkg::*;
#(
    parameter  int N_CH  = DEF_N_CH,
    localparam int IDX_W = idx_w(N_CH)
) (
    input  logic [N_CH-1:0]  req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [IDX_W-1:0] grant_idx,
    output logic             grant_any
);

    int               cand;
    logic [IDX_W-1:0] cand_idx;

    // Scan from the farthest offset down so the nearest requester is written last.
    always_comb begin
        grant_idx = '0;
        grant_any = 1'b0;
        cand      = 0;
        cand_idx  = '0;
        for (int k = N_CH; k >= 1; k--) begin
            cand     = (int'(last_grant) + k) % N_CH;
            cand_idx = cand[IDX_W-1:0];
            if (req[cand_idx]) begin
                grant_idx = cand_idx;
                grant_any = 1'b1;
            end
        end
    end

endmodule

// File: rtl/filter_scheduler.sv
// Time-shares one averaging filter between N_CH period-measurement channels,
// forwarding M_SAMPLES samples per grant and publishing the filter's average.
module filter_scheduler
    import filter_scheduler_pkg::*;
#(
    parameter  int N_CH      = DEF_N_CH,
    parameter  int M_SAMPLES = DEF_M_SAMPLES,
    parameter  int TIMEOUT   = DEF_TIMEOUT,
    localparam int IDX_W     = idx_w(N_CH)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [N_CH-1:0]    ch_req,
    input  logic [N_CH-1:0]    ch_valid,
    input  logic [N_CH*32-1:0] ch_data,
    output logic [N_CH-1:0]    ch_ack,
    output logic [31:0]        flt_data,
    output logic               flt_valid,
    output logic               flt_clear,
    input  logic [31:0]        flt_out,
    input  logic               flt_out_valid,
    output logic [31:0]        res_data,
    output logic [IDX_W-1:0]   res_ch,
    output logic               res_valid,
    output logic               err,
    output logic               busy
);

    localparam int CNT_W = $clog2(M_SAMPLES) + 1;
    localparam int TMR_W = $clog2(TIMEOUT) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(M_SAMPLES - 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] grant_q, grant_d;
    logic [IDX_W-1:0] last_grant_q, last_grant_d;
    logic [CNT_W-1:0] sample_cnt_q, sample_cnt_d;
    logic [TMR_W-1:0] timer_q, timer_d;
    logic [N_CH-1:0]  ch_ack_q, ch_ack_d;
    logic [31:0]      flt_data_q, flt_data_d;
    logic [31:0]      res_data_q, res_data_d;
    logic [IDX_W-1:0] res_ch_q, res_ch_d;
    logic             flt_valid_q, flt_valid_d;
    logic             flt_clear_q, flt_clear_d;
    logic             res_valid_q, res_valid_d;
    logic             err_q, err_d;
    logic             busy_q, busy_d;

    logic [IDX_W-1:0] arb_idx;
    logic             arb_any;
    logic [31:0]      sel_data;
    logic             timeout_hit;
    logic             abort;

    rr_arbiter #(.N_CH(N_CH)) u_arb (
        .req        (ch_req),
        .last_grant (last_grant_q),
        .grant_idx  (arb_idx),
        .grant_any  (arb_any)
    );

    // The timer reaches TIMEOUT on the increment out of TMR_LAST; abort then instead.
    assign timeout_hit = (timer_q == TMR_LAST);
    assign abort = ((state_q == ST_COLLECT) && (!ch_req[grant_q] || timeout_hit)) ||
                   ((state_q == ST_WAIT_RES) && timeout_hit);

    always_comb begin
        sel_data = '0;
        for (int i = 0; i < N_CH; i++) begin
            if (grant_q == IDX_W'(i)) sel_data = ch_data[32*i +: 32];
        end
    end

    always_comb begin
        state_d      = state_q;
        grant_d      = grant_q;
        last_grant_d = last_grant_q;
        sample_cnt_d = sample_cnt_q;
        timer_d      = timer_q;
        ch_ack_d     = '0;
        flt_valid_d  = 1'b0;
        flt_clear_d  = 1'b0;
        res_valid_d  = 1'b0;
        err_d        = 1'b0;
        flt_data_d   = flt_data_q;
        res_data_d   = res_data_q;
        res_ch_d     = res_ch_q;
        if (abort) begin
            flt_clear_d  = 1'b1;
            err_d        = 1'b1;
            last_grant_d = grant_q;
            state_d      = ST_IDLE;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (arb_any) begin
                        grant_d      = arb_idx;
                        sample_cnt_d = '0;
                        timer_d      = '0;
                        state_d      = ST_COLLECT;
                    end
                end
                ST_COLLECT: begin
                    if (ch_valid[grant_q]) begin
                        ch_ack_d[grant_q] = 1'b1;
                        flt_valid_d       = 1'b1;
                        flt_data_d        = sel_data;
                        sample_cnt_d      = sample_cnt_q + CNT_W'(1);
                        timer_d           = '0;
                        if (sample_cnt_q == CNT_LAST) state_d = ST_WAIT_RES;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                ST_WAIT_RES: begin
                    if (flt_out_valid) begin
                        res_data_d = flt_out;
                        state_d    = ST_PUBLISH;
                    end else begin
                        timer_d = timer_q + TMR_W'(1);
                    end
                end
                ST_PUBLISH: begin
                    res_valid_d  = 1'b1;
                    res_ch_d     = grant_q;
                    last_grant_d = grant_q;
                    state_d      = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= ST_IDLE;
            grant_q      <= '0;
            last_grant_q <= IDX_W'(N_CH - 1);
            sample_cnt_q <= '0;
            timer_q      <= '0;
            ch_ack_q     <= '0;
            flt_data_q   <= '0;
            res_data_q   <= '0;
            res_ch_q     <= '0;
            flt_valid_q  <= 1'b0;
            flt_clear_q  <= 1'b0;
            res_valid_q  <= 1'b0;
            err_q        <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            grant_q      <= grant_d;
            last_grant_q <= last_grant_d;
            sample_cnt_q <= sample_cnt_d;
            timer_q      <= timer_d;
            ch_ack_q     <= ch_ack_d;
            flt_data_q   <= flt_data_d;
            res_data_q   <= res_data_d;
            res_ch_q     <= res_ch_d;
            flt_valid_q  <= flt_valid_d;
            flt_clear_q  <= flt_clear_d;
            res_valid_q  <= res_valid_d;
            err_q        <= err_d;
            busy_q       <= busy_d;
        end
    end

    assign ch_ack    = ch_ack_q;
    assign flt_data  = flt_data_q;
    assign flt_valid = flt_valid_q;
    assign flt_clear = flt_clear_q;
    assign res_data  = res_data_q;
    assign res_ch    = res_ch_q;
    assign res_valid = res_valid_q;
    assign err       = err_q;
    assign busy      = busy_q;

endmodule

// File: tb/tb_filter_scheduler.sv
// Directed bench for filter_scheduler: single batch, round robin, abort,
// timeout, stray valids and mid-batch reset.
module tb_filter_scheduler;

    localparam int N_CH    = 4;
    localparam int M       = 16;
    localparam int TIMEOUT = 1024;

    logic         clk = 1'b0;
    logic         reset;
    logic [3:0]   ch_req, ch_valid, ch_ack;
    logic [127:0] ch_data;
    logic [31:0]  flt_data, flt_out, res_data;
    logic         flt_valid, flt_clear, flt_out_valid, res_valid, err, busy;
    logic [1:0]   res_ch;

    int total = 0;
    int bad   = 0;
    int n_res = 0;

    filter_scheduler #(.N_CH(N_CH), .M_SAMPLES(M), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .reset(reset), .ch_req(ch_req), .ch_valid(ch_valid), .ch_data(ch_data),
        .ch_ack(ch_ack), .flt_data(flt_data), .flt_valid(flt_valid), .flt_clear(flt_clear),
        .flt_out(flt_out), .flt_out_valid(flt_out_valid), .res_data(res_data), .res_ch(res_ch),
        .res_valid(res_valid), .err(err), .busy(busy)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
        if (res_valid === 1'b1) n_res++;
    endtask

    task automatic apply_reset();
        reset = 1'b1; ch_req = '0; ch_valid = '0; flt_out_valid = 1'b0;
        tick(); tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1; ch_req = 4'hF; ch_valid = 4'hF; ch_data = '1;
        flt_out = 32'hFFFF_FFFF; flt_out_valid = 1'b1;
        tick(); tick();
        total++;
        if ({ch_ack, flt_valid, flt_clear, res_valid, err, busy} !== 9'd0) begin
            bad++; $display("FAIL reset_ctrl: got %b want 0", {ch_ack, flt_valid, flt_clear, res_valid, err, busy});
        end
        total++;
        if (flt_data !== 32'd0 || res_data !== 32'd0 || res_ch !== 2'd0) begin
            bad++; $display("FAIL reset_data: got flt=%0d res=%0d ch=%0d want 0", flt_data, res_data, res_ch);
        end
        reset = 1'b0; ch_req = '0; ch_valid = '0; flt_out_valid = 1'b0; ch_data = '0;
        tick();
    endtask

    task automatic test_single();
        ch_data = '0; ch_data[31:0] = 32'd1000; ch_req = 4'b0001;
        tick();
        total++;
        if (busy !== 1'b1) begin bad++; $display("FAIL single_busy: got %b want 1", busy); end
        for (int i = 0; i < M; i++) begin
            ch_valid = 4'b0001;
            tick();
            total++;
            if (ch_ack !== 4'b0001 || flt_valid !== 1'b1 || flt_data !== 32'd1000) begin
                bad++; $display("FAIL single_sample[%0d]: got ack=%b v=%b d=%0d want 0001 1 1000", i, ch_ack, flt_valid, flt_data);
            end
        end
        // drop the request right after the last sample: must not abort
        ch_valid = '0; ch_req = '0; n_res = 0;
        tick();
        total++;
        if (flt_valid !== 1'b0 || busy !== 1'b1 || err !== 1'b0) begin
            bad++; $display("FAIL single_wait: got v=%b busy=%b err=%b want 0 1 0", flt_valid, busy, err);
        end
        flt_out = 32'd1000; flt_out_valid = 1'b1;
        tick();
        flt_out_valid = 1'b0;
        tick();
        total++;
        if (res_valid !== 1'b1 || res_ch !== 2'd0 || res_data !== 32'd1000 || busy !== 1'b0) begin
            bad++; $display("FAIL single_publish: got rv=%b ch=%0d d=%0d busy=%b want 1 0 1000 0", res_valid, res_ch, res_data, busy);
        end
        tick();
        total++;
        if (res_valid !== 1'b0 || n_res != 1) begin
            bad++; $display("FAIL single_pulse: got rv=%b count=%0d want 0 1", res_valid, n_res);
        end
    endtask

    task automatic test_round_robin();
        int         exp_ch [5] = '{0, 1, 2, 3, 0};
        logic [3:0] m;
        int         w;
        apply_reset();
        ch_data = {32'd400, 32'd300, 32'd200, 32'd100};
        ch_req = 4'hF; ch_valid = 4'hF;
        for (int b = 0; b < 5; b++) begin
            m = 4'b0001 << exp_ch[b];
            n_res = 0;
            w = 0;
            while (ch_ack === 4'b0000 && w < 8) begin tick(); w++; end
            total++;
            if (ch_ack !== m) begin bad++; $display("FAIL rr_grant[%0d]: got %b want %b", b, ch_ack, m); end
            for (int j = 1; j < M; j++) begin
                tick();
                total++;
                if (ch_ack !== m || flt_data !== 32'(100 * (exp_ch[b] + 1))) begin
                    bad++; $display("FAIL rr_sample[%0d.%0d]: got ack=%b d=%0d want %b %0d", b, j, ch_ack, flt_data, m, 100 * (exp_ch[b] + 1));
                end
            end
            tick();
            total++;
            if (ch_ack !== 4'b0000) begin bad++; $display("FAIL rr_wait_ack[%0d]: got %b want 0000", b, ch_ack); end
            flt_out = 32'd7 + 32'(b); flt_out_valid = 1'b1;
            tick();
            flt_out_valid = 1'b0;
            tick();
            total++;
            if (res_valid !== 1'b1 || res_ch !== 2'(exp_ch[b]) || res_data !== 32'd7 + 32'(b) || n_res != 1) begin
                bad++; $display("FAIL rr_publish[%0d]: got rv=%b ch=%0d d=%0d n=%0d want 1 %0d %0d 1", b, res_valid, res_ch, res_data, n_res, exp_ch[b], 7 + b);
            end
        end
        ch_req = '0; ch_valid = '0;
    endtask

    task automatic test_abort();
        apply_reset();
        ch_data = {32'd400, 32'd300, 32'd200, 32'd100};
        ch_req = 4'b0100; ch_valid = 4'b0100;
        tick();
        for (int i = 0; i < 5; i++) begin
            tick();
            total++;
            if (ch_ack !== 4'b0100) begin bad++; $display("FAIL abort_sample[%0d]: got %b want 0100", i, ch_ack); end
        end
        // request drops while a sample is still offered: abort must win
        ch_req = '0; n_res = 0;
        tick();
        total++;
        if (err !== 1'b1 || flt_clear !== 1'b1 || ch_ack !== 4'b0000 || flt_valid !== 1'b0 || busy !== 1'b0) begin
            bad++; $display("FAIL abort_pulse: got err=%b clr=%b ack=%b v=%b busy=%b want 1 1 0000 0 0", err, flt_clear, ch_ack, flt_valid, busy);
        end
        tick();
        total++;
        if (err !== 1'b0 || flt_clear !== 1'b0) begin
            bad++; $display("FAIL abort_once: got err=%b clr=%b want 0 0", err, flt_clear);
        end
        ch_req = 4'hF; ch_valid = 4'hF;
        tick(); tick();
        total++;
        if (ch_ack !== 4'b1000 || n_res != 0) begin
            bad++; $display("FAIL abort_next: got ack=%b n_res=%0d want 1000 0", ch_ack, n_res);
        end
        ch_req = '0; ch_valid = '0;
    endtask

    task automatic test_timeout();
        int acks = 0;
        int k = 0;
        apply_reset();
        ch_data = '0; ch_data[31:0] = 32'd55;
        ch_req = 4'b0001; ch_valid = 4'b0001;
        tick();
        for (int i = 0; i < M; i++) begin
            tick();
            if (ch_ack === 4'b0001) acks++;
        end
        total++;
        if (acks != M) begin bad++; $display("FAIL timeout_acks: got %0d want %0d", acks, M); end
        ch_req = '0; ch_valid = '0; n_res = 0;
        while (err !== 1'b1 && k < TIMEOUT + 16) begin tick(); k++; end
        total++;
        if (k != TIMEOUT) begin bad++; $display("FAIL timeout_delay: got %0d want %0d", k, TIMEOUT); end
        total++;
        if (busy !== 1'b0 || flt_clear !== 1'b1 || n_res != 0) begin
            bad++; $display("FAIL timeout_state: got busy=%b clr=%b n_res=%0d want 0 1 0", busy, flt_clear, n_res);
        end
        tick();
    endtask

    task automatic test_nongranted();
        apply_reset();
        ch_data = '0; ch_data[31:0] = 32'd2000; ch_data[63:32] = 32'd9999;
        ch_req = 4'b0001; n_res = 0;
        tick();
        ch_valid = 4'b0010; flt_out = 32'd123; flt_out_valid = 1'b1;
        tick();
        flt_out_valid = 1'b0;
        total++;
        if (ch_ack !== 4'b0000 || flt_valid !== 1'b0) begin
            bad++; $display("FAIL stray_ack: got ack=%b v=%b want 0000 0", ch_ack, flt_valid);
        end
        for (int i = 0; i < M; i++) begin
            ch_valid = (i % 4 == 0) ? 4'b0011 : 4'b0001;
            tick();
            total++;
            if (ch_ack !== 4'b0001 || flt_data !== 32'd2000) begin
                bad++; $display("FAIL stray_sample[%0d]: got ack=%b d=%0d want 0001 2000", i, ch_ack, flt_data);
            end
        end
        ch_valid = 4'b0001; ch_req = '0;
        tick();
        total++;
        if (ch_ack !== 4'b0000) begin bad++; $display("FAIL stray_count: got ack=%b want 0000", ch_ack); end
        ch_valid = '0; flt_out = 32'd2000; flt_out_valid = 1'b1;
        tick();
        flt_out_valid = 1'b0;
        tick();
        total++;
        if (res_valid !== 1'b1 || res_data !== 32'd2000 || res_ch !== 2'd0 || n_res != 1) begin
            bad++; $display("FAIL stray_publish: got rv=%b d=%0d ch=%0d n=%0d want 1 2000 0 1", res_valid, res_data, res_ch, n_res);
        end
        tick();
    endtask

    task automatic test_reset_mid();
        ch_data[63:32] = 32'd777;
        ch_req = 4'b0010; ch_valid = 4'b0010;
        tick();
        for (int i = 0; i < 8; i++) begin
            tick();
            total++;
            if (ch_ack !== 4'b0010 || flt_data !== 32'd777) begin
                bad++; $display("FAIL mid_sample[%0d]: got ack=%b d=%0d want 0010 777", i, ch_ack, flt_data);
            end
        end
        reset = 1'b1;
        tick();
        total++;
        if ({ch_ack, flt_valid, flt_clear, res_valid, err, busy} !== 9'd0 ||
            flt_data !== 32'd0 || res_data !== 32'd0 || res_ch !== 2'd0) begin
            bad++; $display("FAIL mid_reset: got ctrl=%b flt=%0d res=%0d ch=%0d want all 0",
                            {ch_ack, flt_valid, flt_clear, res_valid, err, busy}, flt_data, res_data, res_ch);
        end
        reset = 1'b0; ch_req = 4'hF; ch_valid = 4'hF;
        tick(); tick();
        total++;
        if (ch_ack !== 4'b0001) begin bad++; $display("FAIL mid_regrant: got %b want 0001", ch_ack); end
        ch_req = '0; ch_valid = '0;
        tick(); tick();
    endtask

    initial begin
        reset = 1'b1; ch_req = '0; ch_valid = '0; ch_data = '0;
        flt_out = '0; flt_out_valid = 1'b0;
        test_reset();
        test_single();
        test_round_robin();
        test_abort();
        test_timeout();
        test_nongranted();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
